// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of the shared SPI engine
// for the LCD, flash and SD command streams.
module spi_bus_arbiter #(
    parameter int CS_GAP  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Resetn,
    input  logic [2:0]  req_valid,
    input  logic [26:0] req_cmd,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    output logic        spi_valid,
    output logic [7:0]  spi_cmd,
    output logic        spi_mode,
    input  logic        spi_ready,
    output logic [1:0]  spi_sel,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        timeout
);

    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam state_t DONE_ST = (CS_GAP == 0) ? IDLE : GAP;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    win;
    logic [WW-1:0] wd_q, wd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [8:0]    own_word;
    logic          own_valid;
    logic          own_last;
    logic          to_hit;
    logic          accept;

    // Scan starts just after the previous winner.
    always_comb begin
        unique case (rr_q)
            2'd0:
                win = req_valid[1] ? 2'd1 :
                      req_valid[2] ? 2'd2 : 2'd0;
            2'd1:
                win = req_valid[2] ? 2'd2 :
                      req_valid[0] ? 2'd0 : 2'd1;
            default:
                win = req_valid[0] ? 2'd0 :
                      req_valid[1] ? 2'd1 : 2'd2;
        endcase
    end

    always_comb begin
        unique case (owner_q)
            2'd1: begin
                own_word  = req_cmd[17:9];
                own_valid = req_valid[1];
                own_last  = req_last[1];
            end
            2'd2: begin
                own_word  = req_cmd[26:18];
                own_valid = req_valid[2];
                own_last  = req_last[2];
            end
            default: begin
                own_word  = req_cmd[8:0];
                own_valid = req_valid[0];
                own_last  = req_last[0];
            end
        endcase
    end

    // Watchdog fires on the cycle the count would reach TIMEOUT-1.
    assign to_hit = (state_q == XFER) && (wd_q == WW'(TIMEOUT - 2));
    assign accept = spi_valid && spi_ready;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            rr_q    <= 2'd2;
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = win;
                    rr_d    = win;
                    wd_d    = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    wd_d = '0;
                    if (own_last) begin
                        gap_d   = '0;
                        state_d = DONE_ST;
                    end
                end else if (to_hit) begin
                    gap_d   = '0;
                    state_d = DONE_ST;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            GAP: begin
                if (gap_q == GW'(CS_GAP - 1))
                    state_d = IDLE;
                else
                    gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = 3'b000;
        spi_sel   = 2'd0;
        spi_valid = 1'b0;
        spi_cmd   = 8'h00;
        spi_mode  = 1'b0;
        req_ready = 3'b000;
        timeout   = to_hit;
        busy      = (state_q != IDLE);
        if (state_q == XFER) begin
            grant     = 3'b001 << owner_q;
            spi_sel   = owner_q + 2'd1;
            spi_valid = own_valid && !to_hit;
            spi_cmd   = own_word[7:0];
            spi_mode  = own_word[8];
            req_ready = (spi_ready && !to_hit) ? grant : 3'b000;
        end
    end

endmodule
